program_counter: RTL

- Program counter stage directly downstream of the jump-control block. It consumes the 1-bit jump decision, plus a target address from the instruction decoder, and produces the next fetch address.
- Also implements a small hardware return-address stack for CALL/RET, and a RUN/HALT/ERROR state machine.
- o_pc drives instruction memory address; o_halted and o_stack_err go to the control/debug logic.

---
 rtl/program_counter_if.sv | 30 +++
 rtl/program_counter.sv | 89 ++++++++
 2 files changed

// File: rtl/program_counter_if.sv
// Fetch-side bus between control logic and the program counter:
// jump/call/return/halt requests in, fetch address and status out.
interface program_counter_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic                  i_enable;
  logic                  i_jump;
  logic                  i_call;
  logic                  i_ret;
  logic [ADDR_WIDTH-1:0] i_target;
  logic                  i_halt;
  logic                  i_resume;
  logic [ADDR_WIDTH-1:0] o_pc;
  logic [DEPTH_W-1:0]    o_depth;
  logic                  o_halted;
  logic                  o_stack_err;

  modport master (
    output i_enable, i_jump, i_call, i_ret, i_target, i_halt, i_resume,
    input  o_pc, o_depth, o_halted, o_stack_err
  );

  modport slave (
    input  i_enable, i_jump, i_call, i_ret, i_target, i_halt, i_resume,
    output o_pc, o_depth, o_halted, o_stack_err
  );
endinterface

// File: rtl/program_counter.sv
// Program counter with a small return-address stack and a RUN/HALT/ERROR
// state machine. Requests resolve by fixed priority:
// halt > ret > call > jump > increment.
module program_counter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0
) (
  input logic               i_clk,
  input logic               i_rst,
  program_counter_if.slave  bus
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W   = $clog2(STACK_DEPTH);

  typedef enum logic [1:0] {S_RUN, S_HALT, S_ERR} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];
  logic [PTR_W-1:0]      push_idx;
  logic [PTR_W-1:0]      pop_idx;
  logic                  empty;
  logic                  full;

  // Stack pointers derived from the current depth; push_idx is only used
  // when not full and pop_idx only when not empty, so truncation is safe.
  always_comb begin
    push_idx = bus.o_depth[PTR_W-1:0];
    pop_idx  = push_idx - 1'b1;
    empty    = (bus.o_depth == '0);
    full     = (bus.o_depth == DEPTH_W'(STACK_DEPTH));
  end

  // State machine, PC, stack and registered status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= S_RUN;
      bus.o_pc        <= ADDR_WIDTH'(RESET_ADDR);
      bus.o_depth     <= '0;
      bus.o_halted    <= 1'b0;
      bus.o_stack_err <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else if (bus.i_enable) begin
      case (state)
        S_RUN: begin
          if (bus.i_halt) begin
            state        <= S_HALT;
            bus.o_halted <= 1'b1;
          end else if (bus.i_ret) begin
            if (!empty) begin
              bus.o_pc    <= stack[pop_idx];
              bus.o_depth <= bus.o_depth - 1'b1;
            end else begin
              // Underflow is fatal until reset.
              state           <= S_ERR;
              bus.o_halted    <= 1'b1;
              bus.o_stack_err <= 1'b1;
            end
          end else if (bus.i_call) begin
            if (!full) begin
              stack[push_idx] <= bus.o_pc + 1'b1;
              bus.o_pc        <= bus.i_target;
              bus.o_depth     <= bus.o_depth + 1'b1;
            end else begin
              // Overflow: drop the push, freeze, latch the error.
              state           <= S_ERR;
              bus.o_halted    <= 1'b1;
              bus.o_stack_err <= 1'b1;
            end
          end else if (bus.i_jump) begin
            bus.o_pc <= bus.i_target;
          end else begin
            bus.o_pc <= bus.o_pc + 1'b1;
          end
        end
        S_HALT: begin
          if (bus.i_resume) begin
            state        <= S_RUN;
            bus.o_halted <= 1'b0;
          end
        end
        default: begin
          // ERROR: everything frozen until reset.
          state <= S_ERR;
        end
      endcase
    end
  end
endmodule
